// File: rtl/mvec_seq.sv
// rtl/mvec_seq.sv - sequential stream-fed 4x4 matrix x 4-vector transform engine
//
// Holds a 4x4 matrix loaded row by row from the input stream. Each accepted
// vertex is transformed with one row dot-product per cycle. The packed result
// is then presented on the output stream until the consumer takes it.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     input word valid
//   in_ready     input word accepted on in_valid && in_ready
//   in_kind      0 = matrix row {a0,a1,a2,a3}, 1 = vertex {x,y,z,w}
//   in_data      4*W packed word, element 0 in the most significant slot
//   out_valid    result valid (held until out_ready)
//   out_ready    downstream accepts result
//   out_data     result {c0,c1,c2,c3}
//   mat_loaded   four rows have been written since reset
//
// Build option: define MVEC_SATURATE_EN to clamp each result element to
// 2^W-1 instead of keeping the low W bits of the dot-product sum.

module mvec_seq #(
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_kind,
  input  logic [4*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data,
  output logic           mat_loaded
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     row_ptr_q, row_ptr_d;
  logic [1:0]     k_q, k_d;
  logic           mat_loaded_q, mat_loaded_d;
  logic [4*W-1:0] mat_q [4];
  logic [4*W-1:0] mat_d [4];
  logic [4*W-1:0] vtx_q, vtx_d;
  logic [4*W-1:0] res_q, res_d;

  logic           in_acc;
  logic [2*W-1:0] prod [4];
  logic [2*W+1:0] dot_sum;
  logic [W-1:0]   dot_elem;

  // Dot product of the latched vertex with matrix row k.
  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < 4; i++) begin
      prod[i] = {{W{1'b0}}, vtx_q[(3-i)*W +: W]} *
                {{W{1'b0}}, mat_q[k_q][(3-i)*W +: W]};
      dot_sum = dot_sum + {2'b00, prod[i]};
    end
  end

`ifdef MVEC_SATURATE_EN
  // Any bit above the element width means the sum exceeds 2^W-1.
  assign dot_elem = (|dot_sum[2*W+1:W]) ? {W{1'b1}} : dot_sum[W-1:0];
`else
  logic unused_sum_hi;
  assign dot_elem      = dot_sum[W-1:0];
  assign unused_sum_hi = ^dot_sum[2*W+1:W];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && in_ready && in_kind) state_d = S_CALC;
      S_CALC:  if (k_q == 2'd3) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath updates.
  always_comb begin
    in_ready     = (state_q == S_IDLE) && (!in_kind || mat_loaded_q);
    out_valid    = (state_q == S_OUT);
    out_data     = res_q;
    mat_loaded   = mat_loaded_q;
    in_acc       = in_valid && in_ready;

    row_ptr_d    = row_ptr_q;
    k_d          = k_q;
    mat_loaded_d = mat_loaded_q;
    mat_d        = mat_q;
    vtx_d        = vtx_q;
    res_d        = res_q;

    // Rows overwrite in order even after the matrix is complete; there is
    // no reload lock, so a later vertex may see a partially reloaded matrix.
    if (in_acc && !in_kind) begin
      mat_d[row_ptr_q] = in_data;
      row_ptr_d        = row_ptr_q + 2'd1;
      if (row_ptr_q == 2'd3) mat_loaded_d = 1'b1;
    end

    if (in_acc && in_kind) begin
      vtx_d = in_data;
      k_d   = 2'd0;
    end

    // Result slots are only written here, so out_data is frozen in OUT.
    if (state_q == S_CALC) begin
      res_d[(3 - int'(k_q))*W +: W] = dot_elem;
      k_d                           = k_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_ptr_q    <= '0;
      k_q          <= '0;
      mat_loaded_q <= 1'b0;
      vtx_q        <= '0;
      res_q        <= '0;
      for (int r = 0; r < 4; r++) mat_q[r] <= '0;
    end else begin
      row_ptr_q    <= row_ptr_d;
      k_q          <= k_d;
      mat_loaded_q <= mat_loaded_d;
      vtx_q        <= vtx_d;
      res_q        <= res_d;
      for (int r = 0; r < 4; r++) mat_q[r] <= mat_d[r];
    end
  end

endmodule

// File: tb/tb_mvec_seq.sv
// tb/tb_mvec_seq.sv - self-checking bench for mvec_seq

module tb_mvec_seq;

  localparam int W  = 10;
  localparam int WD = 4 * W;
  localparam int EMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_kind = 1'b0;
  logic [WD-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [WD-1:0] out_data;
  logic          mat_loaded;

  mvec_seq #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mat_loaded (mat_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_mat [4][4];
  int            m_ptr;
  bit            m_loaded;
  bit            m_busy;
  int            m_acc_cyc;
  int            cyc = 0;
  logic [WD-1:0] m_exp;
  logic [WD-1:0] m_last;

  function automatic logic [WD-1:0] transform(input logic [WD-1:0] v);
    logic [WD-1:0] r;
    longint        s;
    longint        e;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int j = 0; j < 4; j++)
        s += longint'(m_mat[k][j]) * longint'(v[(3-j)*W +: W]);
`ifdef MVEC_SATURATE_EN
      e = (s > EMAX) ? EMAX : s;
`else
      e = s % (EMAX + 1);
`endif
      r[(3-k)*W +: W] = W'(e);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) m_mat[k][j] = 0;
    m_ptr     = 0;
    m_loaded  = 1'b0;
    m_busy    = 1'b0;
    m_acc_cyc = 0;
    m_exp     = '0;
    m_last    = '0;
  endtask

  // Model advances on each edge: a vertex occupies the engine from its
  // accept edge, its result is visible 4 edges later, and it frees the
  // engine on the output handshake.
  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    bit ov;
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      rdy = !m_busy && (!in_kind || m_loaded);
      ov  = m_busy && ((cyc - 1) >= m_acc_cyc + 4);
      if (ov && out_ready) begin
        m_busy = 1'b0;
        m_last = m_exp;
      end
      if (in_valid && rdy) begin
        if (!in_kind) begin
          for (int j = 0; j < 4; j++) m_mat[m_ptr][j] = int'(in_data[(3-j)*W +: W]);
          if (m_ptr == 3) m_loaded = 1'b1;
          m_ptr = (m_ptr + 1) % 4;
        end else begin
          m_exp     = transform(in_data);
          m_busy    = 1'b1;
          m_acc_cyc = cyc;
        end
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    bit mov;
    if (chk_en && rst_n) begin
      mov = m_busy && (cyc >= m_acc_cyc + 4);
      check_b("in_ready", in_ready, !m_busy && (!in_kind || m_loaded));
      check_b("out_valid", out_valid, mov);
      check_b("mat_loaded", mat_loaded, m_loaded);
      if (mov) check_w("out_data", out_data, m_exp);
      else if (!m_busy) check_w("out_data_hold", out_data, m_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic k, input logic [WD-1:0] d);
    in_valid = v;
    in_kind  = k;
    in_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [WD-1:0] d);
    drive(1'b1, 1'b0, d);
    step();
    drive(1'b0, 1'b0, '0);
  endtask

  // Present a vertex for one edge, then count edges until out_valid.
  task automatic send_vertex(input logic [WD-1:0] d, output int lat);
    drive(1'b1, 1'b1, d);
    step();
    drive(1'b0, 1'b0, '0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int            lat;
    logic [WD-1:0] held;
    logic [WD-1:0] v;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_w("rst_out_data", out_data, '0);
    check_b("rst_mat_loaded", mat_loaded, 1'b0);
    check_b("rst_in_ready_row", in_ready, 1'b1);
    in_kind = 1'b1;
    #1;
    check_b("rst_in_ready_vtx", in_ready, 1'b0);
    in_kind = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Vertex before matrix is refused, even after three rows.
    drive(1'b1, 1'b1, 40'h0040200C04);
    #1;
    check_b("vtx_refused_empty", in_ready, 1'b0);
    idle(3);
    check_b("no_out_empty", out_valid, 1'b0);
    drive(1'b0, 1'b0, '0);
    load_row(40'h0040000000);
    load_row(40'h0000100000);
    load_row(40'h0000000400);
    check_b("not_loaded_3rows", mat_loaded, 1'b0);
    drive(1'b1, 1'b1, 40'h0040200C04);
    #1;
    check_b("vtx_refused_3rows", in_ready, 1'b0);
    step();
    drive(1'b0, 1'b0, '0);

    // Identity transform.
    load_row(40'h0000000001);
    check_b("loaded_4rows", mat_loaded, 1'b1);
    send_vertex(40'h0040200C04, lat);
    check_w("identity_latency", WD'(lat), WD'(4));
    check_w("identity_result", out_data, 40'h0040200C04);
    step();
    check_b("identity_released", out_valid, 1'b0);

    // Backpressure: result held, rows refused while out_ready is low.
    out_ready = 1'b0;
    send_vertex({10'd7, 10'd300, 10'd1023, 10'd12}, lat);
    check_w("bp_latency", WD'(lat), WD'(4));
    held = out_data;
    drive(1'b1, 1'b0, 40'h00FFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_b("bp_row_refused", in_ready, 1'b0);
      check_w("bp_data_stable", out_data, held);
      step();
    end
    drive(1'b0, 1'b0, '0);
    out_ready = 1'b1;
    step();
    check_b("bp_valid_falls", out_valid, 1'b0);
    check_b("bp_ready_rises", in_ready, 1'b1);

    // Overflow: all-ones matrix and vertex.
    for (int r = 0; r < 4; r++) load_row('1);
    send_vertex('1, lat);
`ifdef MVEC_SATURATE_EN
    check_w("overflow_sat", out_data, 40'hFFFFFFFFFF);
`else
    check_w("overflow_wrap", out_data, 40'h0100401004);
`endif
    step();

    // Row wrap: five rows, the fifth lands in row 0.
    load_row({10'd5, 30'd0});
    load_row({10'd6, 30'd0});
    load_row({10'd7, 30'd0});
    load_row({10'd8, 30'd0});
    load_row({10'd9, 30'd0});
    send_vertex({10'd1, 30'd0}, lat);
    check_w("wrap_result", out_data, {10'd9, 10'd6, 10'd7, 10'd8});
    step();
    load_row({10'd11, 30'd0});
    send_vertex({10'd1, 30'd0}, lat);
    check_w("wrap_row_ptr1", out_data, {10'd9, 10'd11, 10'd7, 10'd8});
    step();

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      v = WD'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) v = '1;
      drive(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), v);
      step();
    end
    drive(1'b0, 1'b0, '0);
    out_ready = 1'b1;
    idle(10);

    // Reset two cycles after a vertex accept.
    for (int r = 0; r < 4; r++) load_row(WD'({$urandom(), $urandom()}));
    drive(1'b1, 1'b1, {10'd3, 10'd4, 10'd5, 10'd6});
    #1;
    check_b("mid_rst_vtx_ready", in_ready, 1'b1);
    step();
    drive(1'b0, 1'b0, '0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_b("mid_rst_out_valid", out_valid, 1'b0);
    check_w("mid_rst_out_data", out_data, '0);
    check_b("mid_rst_mat_loaded", mat_loaded, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b1, {10'd3, 10'd4, 10'd5, 10'd6});
    #1;
    check_b("post_rst_vtx_refused", in_ready, 1'b0);
    step();
    drive(1'b0, 1'b0, '0);
    check_b("post_rst_no_out", out_valid, 1'b0);
    load_row({10'd2, 10'd0, 10'd0, 10'd0});
    load_row({10'd0, 10'd2, 10'd0, 10'd0});
    load_row({10'd0, 10'd0, 10'd2, 10'd0});
    load_row({10'd0, 10'd0, 10'd0, 10'd2});
    send_vertex({10'd3, 10'd4, 10'd5, 10'd6}, lat);
    check_w("post_rst_latency", WD'(lat), WD'(4));
    check_w("post_rst_result", out_data, {10'd6, 10'd8, 10'd10, 10'd12});
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
